jtframe_db15_tx: RTL and testbench
==================================

// Module: jtframe_db15_tx
// PURPOSE
// - Console/adapter end of the MiSTer serial DB15 (SNAC) joystick link: it answers the JOY_CLK/JOY_LOAD poll from the frame.
// - Emulates the 74HC165 shift-register chain: latches two players' buttons on LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK.
// - Used in adapter bring-up boards and as the loop-back responder in frame simulations.
// PARAMETERS
// - BITS         24   frame length in bits; fixed layout {joy2[11:0], joy1[11:0]}.
// - SYNC_STAGES  2    flip-flop stages on joy_clk and joy_load; minimum 2.
// - FILT         3    glitch-filter length in clk cycles; used only when JTFRAME_DB15_FILTER_EN is defined.
// PORTS
// - clk          in   1    system clock; must be at least 8x the joy_clk frequency.
// - rst_n        in   1    asynchronous reset, active low.
// - joy1         in   12   player 1 buttons/directions, active high (1 = pressed).
// - joy2         in   12   player 2 buttons/directions, active high.
// - joy_clk      in   1    shift clock from the frame; asynchronous to clk.
// - joy_load     in   1    parallel load, active low; asynchronous to clk.
// - joy_data     out  1    serial data, active low (0 = pressed).
// - busy         out  1    high while a frame is being shifted out.
// - frame_done   out  1    one-cycle pulse after the last bit has been consumed.
// - overrun      out  1    sticky; set when joy_clk toggles beyond BITS. Cleared by the next load.
// BEHAVIOUR
// - Reset values: joy_data=1, busy=0, frame_done=0, overrun=0, shift register all 1s, bit counter 0, state IDLE.
// - Input conditioning:
//   - joy_clk and joy_load each pass through SYNC_STAGES flip-flops, then a 1-cycle edge detector.
//   - An external edge therefore acts SYNC_STAGES+1 clk cycles later (3 cycles by default).
// - State machine:
//   - IDLE -> LOAD when load_s=0.
//   - LOAD: captures sr <= ~{joy2,joy1} on every cycle (transparent), sets cnt=0, clears overrun.
//   - LOAD -> SHIFT on the load_s rising edge. The last captured value is held, and joy_data=sr[0] (bit 0 = joy1[0]).
//   - SHIFT: on each joy_clk rising edge: sr <= {1'b1, sr[BITS-1:1]}, cnt <= cnt+1. joy_data always follows sr[0].
//   - SHIFT -> DONE when cnt reaches BITS-1 and a joy_clk rise occurs. busy falls in the same cycle; frame_done pulses the next cycle.
//   - DONE -> IDLE unconditionally after 1 cycle.
// - busy=1 only in SHIFT.
// - Width/order rules:
//   - The bit counter is ceil(log2(BITS)) bits wide and never wraps.
//   - Bits past BITS read 1 (inactive); the shift register fills with 1s from the top.
// - Boundary conditions:
//   - joy_clk rise in IDLE or DONE: sets overrun=1, joy_data stays 1, no other effect.
//   - joy_clk rise during LOAD: ignored; no shift and no overrun.
//   - load_s falls during SHIFT: aborts the frame and goes to LOAD. No frame_done; the partial frame is discarded.
//   - load_s fall and joy_clk rise in the same cycle: the load wins and the clock edge is dropped.
//   - joy1/joy2 changes during SHIFT: no effect until the next LOAD.
//   - rst_n low at any time: outputs return to their reset values immediately (asynchronous). The synchronizers also clear to 1.
// CONFIGURATION
// - JTFRAME_DB15_FILTER_EN defined:
//   - After synchronization, joy_clk and joy_load each take a new value only after it has been stable for FILT consecutive clk cycles.
//   - Edge latency becomes SYNC_STAGES+FILT+1 (6 by default). Pulses shorter than FILT cycles are discarded.
// - JTFRAME_DB15_FILTER_EN undefined: no filter; latency is SYNC_STAGES+1 and FILT is ignored.
// TESTING
// - Reset release, joy_load=1, no joy_clk -> joy_data=1, busy=0, overrun=0 for 100 cycles.
// - Poll sequence with joy1=12'h001, joy2=12'h800:
//   - Load pulse, then 24 clocks. First bit=0, bits 1..22=1, bit 23=0.
//   - busy falls after the 24th rise; exactly one frame_done pulse.
// - Extra clocks: 26 clocks after a load -> bits 24 and 25 read 1, overrun=1. The next load pulse clears overrun.
// - Abort: load re-asserted after 10 clocks -> no frame_done; the following full frame returns fresh inputs (joy1=12'hA5A reads 0,1,0,1,1,0,1,0,0,1,0,1).
// - Same-cycle event: load fall and clk rise synchronized into the same cycle -> state LOAD, counter 0, no shift.
// - With JTFRAME_DB15_FILTER_EN:
//   - A 2-cycle joy_clk glitch mid-frame -> no shift.
//   - A 4-cycle pulse -> one shift; edge latency measured as 6 cycles.

Source files
------------

// File: rtl/jtframe_db15_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_db15_tx_if                                                   |
// | DB15 serial joystick link: frame-side poll signals and button inputs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface jtframe_db15_tx_if;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        joy_clk;
  logic        joy_load;
  logic        joy_data;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  modport master (
    output joy1, joy2, joy_clk, joy_load,
    input  joy_data, busy, frame_done, overrun
  );

  modport slave (
    input  joy1, joy2, joy_clk, joy_load,
    output joy_data, busy, frame_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_db15_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_db15_tx                                                      |
// | 74HC165-style responder for the MiSTer DB15 (SNAC) joystick poll.    |
// | Optional glitch filter: define JTFRAME_DB15_FILTER_EN                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jtframe_db15_tx #(
  parameter int BITS        = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  jtframe_db15_tx_if.slave  bus
);
  localparam int CW = $clog2(BITS);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   w_clk_s;
  logic                   w_load_s;
  logic                   r_clk_d;
  logic                   r_load_d;
  logic                   w_clk_rise;
  logic                   w_load_rise;
  logic                   w_load_fall;
  logic [BITS-1:0]        w_load_val;

  logic [1:0]             r_state;
  logic [BITS-1:0]        r_sr;
  logic [CW-1:0]          r_cnt;
  logic                   r_overrun;
  logic                   r_frame_done;

  // Synchronizers idle high so a reset never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '1;
      r_load_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.joy_clk};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], bus.joy_load};
    end
  end

`ifdef JTFRAME_DB15_FILTER_EN
  localparam int FW = $clog2(FILT) + 1;

  logic          r_clk_f;
  logic          r_load_f;
  logic [FW-1:0] r_clk_fcnt;
  logic [FW-1:0] r_load_fcnt;

  // A new level is accepted once it has been seen for FILT consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_f     <= 1'b1;
      r_load_f    <= 1'b1;
      r_clk_fcnt  <= '0;
      r_load_fcnt <= '0;
    end else begin
      if (r_clk_sync[SYNC_STAGES-1] == r_clk_f) begin
        r_clk_fcnt <= '0;
      end else if (r_clk_fcnt == FW'(FILT-1)) begin
        r_clk_f    <= r_clk_sync[SYNC_STAGES-1];
        r_clk_fcnt <= '0;
      end else begin
        r_clk_fcnt <= r_clk_fcnt + FW'(1);
      end

      if (r_load_sync[SYNC_STAGES-1] == r_load_f) begin
        r_load_fcnt <= '0;
      end else if (r_load_fcnt == FW'(FILT-1)) begin
        r_load_f    <= r_load_sync[SYNC_STAGES-1];
        r_load_fcnt <= '0;
      end else begin
        r_load_fcnt <= r_load_fcnt + FW'(1);
      end
    end
  end

  assign w_clk_s  = r_clk_f;
  assign w_load_s = r_load_f;
`else
  localparam int c_unused_filt = FILT;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_load_s = r_load_sync[SYNC_STAGES-1];
`endif

  assign w_clk_rise  =  w_clk_s  & ~r_clk_d;
  assign w_load_rise =  w_load_s & ~r_load_d;
  assign w_load_fall = ~w_load_s &  r_load_d;
  // Buttons are active high, the wire is active low.
  assign w_load_val  = ~{bus.joy2, bus.joy1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_d      <= 1'b1;
      r_load_d     <= 1'b1;
      r_state      <= c_IDLE;
      r_sr         <= '1;
      r_cnt        <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_clk_d      <= w_clk_s;
      r_load_d     <= w_load_s;
      r_frame_done <= (r_state == c_DONE);
      case (r_state)
        c_IDLE: begin
          if (!w_load_s)       r_state   <= c_LOAD;
          else if (w_clk_rise) r_overrun <= 1'b1;
        end
        c_LOAD: begin
          r_sr      <= w_load_val;
          r_cnt     <= '0;
          r_overrun <= 1'b0;
          if (w_load_rise) r_state <= c_SHIFT;
        end
        c_SHIFT: begin
          // A new load takes priority over a coincident clock edge.
          if (w_load_fall) begin
            r_state <= c_LOAD;
          end else if (w_clk_rise) begin
            r_sr <= {1'b1, r_sr[BITS-1:1]};
            if (r_cnt == CW'(BITS-1)) r_state <= c_DONE;
            else                      r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
          if (w_clk_rise && w_load_s) r_overrun <= 1'b1;
        end
      endcase
    end
  end

  assign bus.joy_data   = r_sr[0];
  assign bus.busy       = (r_state == c_SHIFT);
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_jtframe_db15_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_jtframe_db15_tx                                                   |
// | Directed bench for the DB15 joystick responder.                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jtframe_db15_tx;
`ifdef JTFRAME_DB15_FILTER_EN
  localparam int LAT = 6;
  localparam int HP  = 8;
`else
  localparam int LAT = 3;
  localparam int HP  = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  jtframe_db15_tx_if bus ();

  jtframe_db15_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && bus.frame_done === 1'b1) done_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse();
    bus.joy_load = 1'b0;
    cycles(LAT + 2);
    bus.joy_load = 1'b1;
    cycles(LAT + 2);
  endtask

  task automatic clk_pulse();
    bus.joy_clk = 1'b1;
    cycles(HP);
    bus.joy_clk = 1'b0;
    cycles(HP);
  endtask

  logic [23:0] exp_bits;
  int          d0;
  int          lat;
  logic [4:0]  c0;

  initial begin
    bus.joy1 = 12'h000;
    bus.joy2 = 12'h000;
    bus.joy_clk  = 1'b0;
    bus.joy_load = 1'b1;
    cycles(5);
    rst_n = 1'b1;

    // Idle link after reset.
    for (int i = 0; i < 100; i++) begin
      chk("reset_idle", {29'd0, bus.joy_data, bus.busy, bus.overrun}, 32'b100);
      cycles(1);
    end
    chk("reset_frame_done", bus.frame_done, 1'b0);

    // Basic poll.
    bus.joy1 = 12'h001;
    bus.joy2 = 12'h800;
    load_pulse();
    chk("frame1_busy_start", bus.busy, 1'b1);
    exp_bits = 24'h7FFFFE;
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("frame1_bit%0d", i), bus.joy_data, exp_bits[i]);
      if (i == 23) chk("frame1_busy_before_last", bus.busy, 1'b1);
      clk_pulse();
    end
    chk("frame1_busy_end", bus.busy, 1'b0);
    chk("frame1_done_pulses", done_cnt - d0, 1);
    chk("frame1_overrun", bus.overrun, 1'b0);

    // Extra clocks beyond the frame.
    load_pulse();
    for (int i = 0; i < 24; i++) clk_pulse();
    for (int i = 24; i < 26; i++) begin
      chk($sformatf("extra_bit%0d", i), bus.joy_data, 1'b1);
      clk_pulse();
    end
    chk("extra_overrun_set", bus.overrun, 1'b1);
    chk("extra_state_idle", dut.r_state, 2'd0);
    load_pulse();
    chk("extra_overrun_cleared", bus.overrun, 1'b0);

    // Abort after 10 clocks; inputs changed mid-frame must not leak in.
    bus.joy1 = 12'h000;
    bus.joy2 = 12'h000;
    load_pulse();
    for (int i = 0; i < 5; i++) clk_pulse();
    bus.joy1 = 12'hA5A;
    for (int i = 5; i < 10; i++) begin
      chk($sformatf("abort_old_bit%0d", i), bus.joy_data, 1'b1);
      clk_pulse();
    end
    d0 = done_cnt;
    load_pulse();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_cnt_restart", dut.r_cnt, 5'd0);
    // Decoded buttons 0,1,0,1,1,0,1,0,0,1,0,1 then player 2 idle.
    exp_bits = 24'hFFF5A5;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("abort_fresh_bit%0d", i), bus.joy_data, exp_bits[i]);
      clk_pulse();
    end
    chk("abort_fresh_done", done_cnt - d0, 1);

    // Load fall and clock rise seen in the same cycle.
    load_pulse();
    for (int i = 0; i < 3; i++) clk_pulse();
    bus.joy1 = 12'h001;
    bus.joy_load = 1'b0;
    bus.joy_clk  = 1'b1;
    cycles(LAT + 2);
    chk("same_state_load", dut.r_state, 2'd1);
    chk("same_cnt", dut.r_cnt, 5'd0);
    chk("same_overrun", bus.overrun, 1'b0);
    chk("same_data_fresh", bus.joy_data, 1'b0);

    // Clock toggles while held in load are ignored.
    bus.joy_clk = 1'b0;
    cycles(HP);
    clk_pulse();
    chk("load_clk_state", dut.r_state, 2'd1);
    chk("load_clk_cnt", dut.r_cnt, 5'd0);
    chk("load_clk_overrun", bus.overrun, 1'b0);
    bus.joy_load = 1'b1;
    cycles(LAT + 2);
    chk("load_clk_to_shift", bus.busy, 1'b1);
    chk("load_clk_bit0", bus.joy_data, 1'b0);

    // Edge latency from the pin to the shift.
    c0 = dut.r_cnt;
    lat = 0;
    bus.joy_clk = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && dut.r_cnt != c0) lat = k;
    end
    chk("edge_latency", lat, LAT);
    cycles(1);
    bus.joy_clk = 1'b0;
    cycles(HP);

    // Short pulses: 2 cycles is a glitch only when filtered; 4 cycles always shifts.
    c0 = dut.r_cnt;
    bus.joy_clk = 1'b1;
    cycles(2);
    bus.joy_clk = 1'b0;
    cycles(12);
`ifdef JTFRAME_DB15_FILTER_EN
    chk("glitch_2cyc", dut.r_cnt, c0);
`else
    chk("glitch_2cyc", dut.r_cnt, c0 + 5'd1);
`endif
    c0 = dut.r_cnt;
    bus.joy_clk = 1'b1;
    cycles(4);
    bus.joy_clk = 1'b0;
    cycles(12);
    chk("pulse_4cyc", dut.r_cnt, c0 + 5'd1);

    // Asynchronous reset mid-frame.
    chk("pre_reset_busy", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {28'd0, bus.joy_data, bus.busy, bus.frame_done, bus.overrun}, 32'b1000);
    chk("async_reset_state", dut.r_state, 2'd0);
    chk("async_reset_cnt", dut.r_cnt, 5'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    chk("post_reset_idle", {29'd0, bus.joy_data, bus.busy, bus.overrun}, 32'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
